div_seq: RTL

DIV_SEQ -- requirements
Module: div_seq

---
 rtl/div_pkg.sv | 32 +++
 rtl/div_step.sv | 25 ++
 rtl/div_seq.sv | 131 +++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: FSM state encoding and
// width-generic special-case constants (all-ones quotient, most-negative value).
// Helpers return 64-bit values; callers size-cast to their operand width.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Quotient reported for a zero divisor: every bit of the operand width set.
  function automatic logic [63:0] all_ones(input int len);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < len) v[i] = 1'b1;
    end
    return v;
  endfunction

  // Two's-complement most-negative value for the operand width.
  function automatic logic [63:0] most_neg(input int len);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 64; i++) begin
      if (i == len - 1) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step, purely combinational.
// Ports: rem_in/dvs/bit_in -> rem_out (new partial remainder), q_bit (quotient bit).
// Operates on unsigned magnitudes only; sign handling belongs to the caller.
module div_step #(
  parameter int LEN = 16
) (
  input  logic [LEN-1:0] rem_in,
  input  logic [LEN-1:0] dvs,
  input  logic           bit_in,
  output logic [LEN-1:0] rem_out,
  output logic           q_bit
);

  logic [LEN:0] shifted;
  logic [LEN:0] diff;

  // rem_in < dvs holds between steps, so shifted < 2*dvs and the difference
  // can never overflow into the extra top bit; that bit is a pure borrow flag.
  // With dvs == 0 the remainder simply accumulates the dividend bits.
  assign shifted = {rem_in, bit_in};
  assign diff    = shifted - {1'b0, dvs};
  assign q_bit   = ~diff[LEN];
  assign rem_out = q_bit ? diff[LEN-1:0] : shifted[LEN-1:0];

endmodule

// File: rtl/div_seq.sv
// Sequential restoring divider (unsigned or two's-complement signed), LEN-cycle fixed latency.
// Ports: CLK, RST_N (sync, active-low); IN_VALID/IN_READY + A/B in; OUT_VALID/OUT_READY + Q/R out.
// One operation in flight; IN_READY only in IDLE, Q/R held in DONE until OUT_READY.
module div_seq
  import div_pkg::*;
#(
  parameter int LEN    = 16,
  parameter bit SIGNED = 1'b0
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic           IN_VALID,
  output logic           IN_READY,
  input  logic [LEN-1:0] A,
  input  logic [LEN-1:0] B,
  output logic           OUT_VALID,
  input  logic           OUT_READY,
  output logic [LEN-1:0] Q,
  output logic [LEN-1:0] R
);

  localparam int            CNT_W = $clog2(LEN);
  localparam logic [LEN-1:0] ONES = LEN'(all_ones(LEN));

  div_state_t state_q, state_d;

  logic [CNT_W-1:0] cnt_q;
  logic [LEN-1:0]   rem_q;     // partial remainder (magnitude)
  logic [LEN-1:0]   dvd_q;     // dividend bits shift out the top, quotient bits shift in
  logic [LEN-1:0]   dvs_q;     // divisor magnitude
  logic             neg_q_q;   // negate quotient at the end
  logic             neg_r_q;   // negate remainder at the end (follows dividend sign)
  logic             bz_q;      // divisor was zero

  logic             a_neg, b_neg;
  logic [LEN-1:0]   a_mag, b_mag;
  logic [LEN-1:0]   rem_nxt;
  logic             q_bit;
  logic [LEN-1:0]   q_mag;
  logic [LEN-1:0]   q_fin, r_fin;
  logic             last_step;

  // Most-negative A negates to itself, which is the correct unsigned magnitude.
  assign a_neg = SIGNED && A[LEN-1];
  assign b_neg = SIGNED && B[LEN-1];
  assign a_mag = a_neg ? -A : A;
  assign b_mag = b_neg ? -B : B;

  div_step #(.LEN(LEN)) u_step (
    .rem_in  (rem_q),
    .dvs     (dvs_q),
    .bit_in  (dvd_q[LEN-1]),
    .rem_out (rem_nxt),
    .q_bit   (q_bit)
  );

  assign q_mag     = {dvd_q[LEN-2:0], q_bit};
  assign last_step = (cnt_q == CNT_W'(LEN - 1));

  // Divide-by-zero: the magnitude datapath already yields R = |A|, and the
  // dividend-sign correction restores A; Q is forced so the divisor sign
  // cannot flip the all-ones pattern.
  assign q_fin = bz_q    ? ONES     : (neg_q_q ? -q_mag : q_mag);
  assign r_fin = neg_r_q ? -rem_nxt : rem_nxt;

  always_ff @(posedge CLK) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    IN_READY  = 1'b0;
    OUT_VALID = 1'b0;
    case (state_q)
      IDLE: begin
        IN_READY = 1'b1;
        if (IN_VALID) state_d = CALC;
      end
      CALC: begin
        if (last_step) state_d = DONE;
      end
      DONE: begin
        OUT_VALID = 1'b1;
        if (OUT_READY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      bz_q    <= 1'b0;
      Q       <= '0;
      R       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (IN_VALID) begin
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= a_mag;
            dvs_q   <= b_mag;
            neg_q_q <= a_neg ^ b_neg;
            neg_r_q <= a_neg;
            bz_q    <= (B == '0);
          end
        end
        CALC: begin
          rem_q <= rem_nxt;
          dvd_q <= q_mag;
          if (last_step) begin
            cnt_q <= '0;
            Q     <= q_fin;
            R     <= r_fin;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
